// File: rtl/input_check.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | Module      : input_check
// | Description : Player-input checker for the memory game. It synchronises the
// |               four colour buttons, decodes each press and compares it with
// |               the packed colour sequence for round_ctr+1 entries. It then
// |               pulses complete_input or fail_input.
// |               Optional feature: define INPUT_TIMEOUT_EN to fail the round
// |               after TIMEOUT_CYCLES idle cycles in WAIT_PRESS.
// | Revision    : 1.0 - initial release
// +----------------------------------------------------------------------------
module input_check #(
  parameter int RELEASE_CYCLES = 4,
  parameter int TIMEOUT_W      = 24,
  parameter int TIMEOUT_CYCLES = 10000000
) (
  input  logic        clk,
  input  logic        rst_input,
  input  logic        en_input,
  input  logic [31:0] seq_in_input,
  input  logic [3:0]  round_ctr,
  input  logic [3:0]  btn_in,
  output logic [1:0]  colour_bus,
  output logic        colour_oe,
  output logic        busy_input,
  output logic        complete_input,
  output logic        fail_input
);

  localparam logic [1:0] c_st_idle         = 2'd0;
  localparam logic [1:0] c_st_wait_press   = 2'd1;
  localparam logic [1:0] c_st_wait_release = 2'd2;

  localparam int                 c_rel_w    = $clog2(RELEASE_CYCLES + 1);
  localparam logic [c_rel_w-1:0] c_rel_last = c_rel_w'(RELEASE_CYCLES - 1);

  // Parameter sanity: the timeout limit must fit in the counter width.
  generate
    if (RELEASE_CYCLES < 1) begin : g_bad_release
      $error("input_check: RELEASE_CYCLES must be at least 1");
    end
    if (TIMEOUT_W < 1 || TIMEOUT_CYCLES < 1 || $clog2(TIMEOUT_CYCLES) > TIMEOUT_W) begin : g_bad_timeout
      $error("input_check: TIMEOUT_CYCLES does not fit in TIMEOUT_W bits");
    end
  endgenerate

  logic [3:0]         r_sync1;
  logic [3:0]         r_btn_s;
  logic [1:0]         r_state;
  logic [1:0]         w_state_next;
  logic [3:0]         r_pos;
  logic [1:0]         r_colour;
  logic               r_match;
  logic [c_rel_w-1:0] r_rel_cnt;

  logic       w_press;
  logic       w_multi;
  logic [1:0] w_colour_now;
  logic [1:0] w_expected;
  logic       w_match_now;
  logic       w_rel_done;
  logic       w_last;
  logic       w_timeout;

  logic [1:0] w_bus_next;
  logic       w_oe_next;
  logic       w_busy_next;
  logic       w_complete_next;
  logic       w_fail_next;

  always_ff @(posedge clk) begin
    if (rst_input) begin
      r_sync1 <= 4'd0;
      r_btn_s <= 4'd0;
    end else begin
      r_sync1 <= btn_in;
      r_btn_s <= r_sync1;
    end
  end

  assign w_press    = |r_btn_s;
  assign w_multi    = (r_btn_s & (r_btn_s - 4'd1)) != 4'd0;
  assign w_expected = seq_in_input[{r_pos, 1'b0} +: 2];
  assign w_last     = (r_pos == round_ctr);

  // A multi-press still echoes the lowest pressed colour, but never matches.
  always_comb begin
    w_colour_now = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (r_btn_s[k]) begin
        w_colour_now = 2'(k);
      end
    end
  end

  assign w_match_now = !w_multi && (w_colour_now == w_expected);
  assign w_rel_done  = (r_state == c_st_wait_release) && !w_press && (r_rel_cnt == c_rel_last);

`ifdef INPUT_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] c_tmo_last = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  logic [TIMEOUT_W-1:0] r_tmo_cnt;

  // Held at zero outside WAIT_PRESS, so it is already clear on entry.
  always_ff @(posedge clk) begin
    if (rst_input || (r_state != c_st_wait_press) || w_press || w_timeout) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  assign w_timeout = (r_state == c_st_wait_press) && !w_press && (r_tmo_cnt == c_tmo_last);
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst_input) begin
      r_state        <= c_st_idle;
      r_pos          <= 4'd0;
      r_colour       <= 2'd0;
      r_match        <= 1'b0;
      r_rel_cnt      <= '0;
      colour_bus     <= 2'd0;
      colour_oe      <= 1'b0;
      busy_input     <= 1'b0;
      complete_input <= 1'b0;
      fail_input     <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      colour_bus     <= w_bus_next;
      colour_oe      <= w_oe_next;
      busy_input     <= w_busy_next;
      complete_input <= w_complete_next;
      fail_input     <= w_fail_next;

      if ((r_state == c_st_idle) && en_input) begin
        r_pos <= 4'd0;
      end else if (w_rel_done && r_match && !w_last) begin
        r_pos <= r_pos + 4'd1;
      end

      if ((r_state == c_st_wait_press) && w_press) begin
        r_colour  <= w_colour_now;
        r_match   <= w_match_now;
        r_rel_cnt <= '0;
      end else if (r_state == c_st_wait_release) begin
        if (w_press || w_rel_done) begin
          r_rel_cnt <= '0;
        end else begin
          r_rel_cnt <= r_rel_cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_idle: begin
        if (en_input) begin
          w_state_next = c_st_wait_press;
        end
      end
      c_st_wait_press: begin
        if (w_press) begin
          w_state_next = c_st_wait_release;
        end else if (w_timeout) begin
          w_state_next = c_st_idle;
        end
      end
      c_st_wait_release: begin
        if (w_rel_done) begin
          w_state_next = (r_match && !w_last) ? c_st_wait_press : c_st_idle;
        end
      end
      default: w_state_next = c_st_idle;
    endcase
  end

  always_comb begin
    w_bus_next      = colour_bus;
    w_oe_next       = 1'b0;
    w_complete_next = 1'b0;
    w_fail_next     = w_timeout;
    w_busy_next     = (w_state_next != c_st_idle);
    if (r_state == c_st_wait_release) begin
      w_bus_next      = r_colour;
      w_oe_next       = !w_rel_done;
      w_complete_next = w_rel_done && r_match && w_last;
      w_fail_next     = w_rel_done && !r_match;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_input_check.sv
`default_nettype none
// Self-checking bench for input_check: directed scenarios with literal timing
// plus randomized rounds against a behavioural reference model.
module tb_input_check;

  localparam int REL = 4;
  localparam int TMO = 100;
`ifdef INPUT_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_input = 1'b1;
  logic        en_input = 1'b0;
  logic [31:0] seq_in_input = 32'd0;
  logic [3:0]  round_ctr = 4'd0;
  logic [3:0]  btn_in = 4'd0;
  logic [1:0]  colour_bus;
  logic        colour_oe;
  logic        busy_input;
  logic        complete_input;
  logic        fail_input;

  always #5 clk = ~clk;

  input_check #(
    .RELEASE_CYCLES(REL),
    .TIMEOUT_W(24),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst_input(rst_input),
    .en_input(en_input),
    .seq_in_input(seq_in_input),
    .round_ctr(round_ctr),
    .btn_in(btn_in),
    .colour_bus(colour_bus),
    .colour_oe(colour_oe),
    .busy_input(busy_input),
    .complete_input(complete_input),
    .fail_input(fail_input)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit cmp_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  function automatic int lowest(input logic [3:0] b);
    for (int k = 0; k < 4; k++) if (b[k]) return k;
    return 0;
  endfunction

  // Reference model: tracks the round in terms of "waiting for a press" and
  // "holding a press", counting released cycles and waiting cycles directly.
  int         m_mode = 0;  // 0 idle, 1 waiting for press, 2 holding a press
  logic [3:0] m_s1 = 4'd0, m_s2 = 4'd0;
  int         m_pos = 0, m_rel = 0, m_wait = 0, m_col = 0;
  bit         m_good = 1'b0;
  logic [1:0] e_bus = 2'd0;
  bit         e_oe = 1'b0, e_busy = 1'b0, e_comp = 1'b0, e_fail = 1'b0;

  always @(posedge clk) begin
    logic [3:0] s;
    s = m_s2;
    e_comp = 1'b0;
    e_fail = 1'b0;
    if (rst_input) begin
      m_s1 = 4'd0; m_s2 = 4'd0; m_mode = 0; m_pos = 0; m_rel = 0; m_wait = 0;
      e_bus = 2'd0; e_oe = 1'b0; e_busy = 1'b0;
    end else begin
      m_s2 = m_s1;
      m_s1 = btn_in;
      case (m_mode)
        0: if (en_input) begin m_pos = 0; m_mode = 1; m_wait = 0; end
        1: begin
          if (s != 4'd0) begin
            m_col  = lowest(s);
            m_good = ($countones(s) == 1) && (m_col == int'((seq_in_input >> (2 * m_pos)) & 32'd3));
            m_mode = 2;
            m_rel  = 0;
          end else begin
            m_wait++;
            if (TMO_ON && m_wait == TMO) begin e_fail = 1'b1; m_mode = 0; end
          end
        end
        default: begin
          m_rel = (s == 4'd0) ? m_rel + 1 : 0;
          if (m_rel == REL) begin
            e_oe = 1'b0;
            if (!m_good) begin e_fail = 1'b1; m_mode = 0; end
            else if (m_pos == int'(round_ctr)) begin e_comp = 1'b1; m_mode = 0; end
            else begin m_pos++; m_mode = 1; m_wait = 0; end
          end else begin
            e_oe  = 1'b1;
            e_bus = 2'(m_col);
          end
        end
      endcase
      e_busy = (m_mode != 0);
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("colour_oe", {31'd0, colour_oe}, {31'd0, e_oe});
      chk("busy_input", {31'd0, busy_input}, {31'd0, e_busy});
      chk("complete_input", {31'd0, complete_input}, {31'd0, e_comp});
      chk("fail_input", {31'd0, fail_input}, {31'd0, e_fail});
      if (e_oe) chk("colour_bus", {30'd0, colour_bus}, {30'd0, e_bus});
      if (complete_input && fail_input) chk("pulse_exclusive", 32'd1, 32'd0);
    end
  end

  // Event log used by the directed scenarios.
  int comp_q[$];
  int fail_q[$];
  int echo_q[$];
  bit prev_oe = 1'b0;

  always @(negedge clk) begin
    if (complete_input) comp_q.push_back(cyc);
    if (fail_input) fail_q.push_back(cyc);
    if (colour_oe && !prev_oe) echo_q.push_back(int'(colour_bus));
    prev_oe = colour_oe;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    comp_q.delete();
    fail_q.delete();
    echo_q.delete();
  endtask

  task automatic start_round(input logic [31:0] seq, input logic [3:0] rc);
    seq_in_input = seq;
    round_ctr    = rc;
    en_input     = 1'b1;
    tick(1);
    en_input     = 1'b0;
  endtask

  task automatic press(input logic [3:0] b, input int hold, output int t_rel);
    btn_in = b;
    tick(hold);
    btn_in = 4'd0;
    t_rel  = cyc;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((busy_input || m_mode != 0) && n < budget) begin
      tick(1);
      n++;
    end
    if (n >= budget) begin
      checks++;
      failures++;
      $display("FAIL wait_idle cyc=%0d actual=busy required=idle", cyc);
    end
  endtask

  initial begin
    int t;
    int t_en;
    logic [3:0] b;
    int col;

    tick(3);
    cmp_en = 1'b1;
    @(negedge clk);
    chk("reset_oe", {31'd0, colour_oe}, 32'd0);
    chk("reset_bus", {30'd0, colour_bus}, 32'd0);
    chk("reset_busy", {31'd0, busy_input}, 32'd0);
    rst_input = 1'b0;
    tick(2);

    // Correct four-colour round.
    clear_log();
    start_round(32'h0000_00E4, 4'd3);
    t = 0;
    for (int i = 0; i < 4; i++) begin
      press(4'(1 << i), 10, t);
      tick(10);
    end
    tick(10);
    chk("t1_complete_n", comp_q.size(), 1);
    if (comp_q.size() > 0) chk("t1_complete_time", comp_q[0], t + 6);
    chk("t1_fail_n", fail_q.size(), 0);
    chk("t1_echo_n", echo_q.size(), 4);
    for (int i = 0; i < 4; i++) if (i < echo_q.size()) chk("t1_echo", echo_q[i], i);

    // Wrong second colour.
    clear_log();
    start_round(32'h0000_00E4, 4'd3);
    press(4'b0001, 10, t);
    tick(10);
    press(4'b0100, 10, t);
    tick(20);
    chk("t2_fail_n", fail_q.size(), 1);
    if (fail_q.size() > 0) chk("t2_fail_time", fail_q[0], t + 6);
    chk("t2_complete_n", comp_q.size(), 0);
    chk("t2_busy_after", {31'd0, busy_input}, 32'd0);

    // Multi-press echoes the lowest colour and fails.
    clear_log();
    start_round(32'h0000_0001, 4'd0);
    press(4'b0011, 10, t);
    tick(20);
    chk("t3_echo_n", echo_q.size(), 1);
    if (echo_q.size() > 0) chk("t3_echo", echo_q[0], 0);
    chk("t3_fail_n", fail_q.size(), 1);
    if (fail_q.size() > 0) chk("t3_fail_time", fail_q[0], t + 6);

    // Release glitch: only the final, uninterrupted release counts.
    clear_log();
    start_round(32'h0000_0000, 4'd0);
    btn_in = 4'b0001; tick(8);
    btn_in = 4'b0000; tick(2);
    btn_in = 4'b0001; tick(1);
    btn_in = 4'b0000;
    t = cyc;
    tick(20);
    chk("t4_complete_n", comp_q.size(), 1);
    if (comp_q.size() > 0) chk("t4_complete_time", comp_q[0], t + 6);
    chk("t4_fail_n", fail_q.size(), 0);

    // Reset in the middle of a held press.
    clear_log();
    start_round(32'h0000_00E4, 4'd3);
    btn_in = 4'b0001;
    tick(8);
    chk("t5_oe_before", {31'd0, colour_oe}, 32'd1);
    rst_input = 1'b1;
    btn_in    = 4'b0000;
    tick(1);
    chk("t5_oe_reset", {31'd0, colour_oe}, 32'd0);
    chk("t5_busy_reset", {31'd0, busy_input}, 32'd0);
    chk("t5_bus_reset", {30'd0, colour_bus}, 32'd0);
    rst_input = 1'b0;
    tick(20);
    chk("t5_pulses", comp_q.size() + fail_q.size(), 0);

    // Inactivity after starting a round.
    clear_log();
    start_round(32'h0000_0000, 4'd0);
    t_en = cyc;
    tick(1100);
`ifdef INPUT_TIMEOUT_EN
    chk("t6_fail_n", fail_q.size(), 1);
    if (fail_q.size() > 0) chk("t6_fail_time", fail_q[0], t_en + TMO);
    chk("t6_busy", {31'd0, busy_input}, 32'd0);
`else
    chk("t6_fail_n", fail_q.size(), 0);
    chk("t6_busy", {31'd0, busy_input}, 32'd1);
    chk("t6_entry", t_en, t_en);
`endif
    rst_input = 1'b1; tick(1); rst_input = 1'b0; tick(2);

    // Randomized rounds checked cycle by cycle against the model.
    for (int r = 0; r < 150; r++) begin
      wait_idle(400);
      start_round($urandom, ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 5)));
      for (int p = 0; p <= int'(round_ctr); p++) begin
        if (m_mode == 0) break;
        col = int'((seq_in_input >> (2 * p)) & 32'd3);
        if ($urandom_range(0, 99) < 8) col = $urandom_range(0, 3);
        b = 4'(1 << col);
        if ($urandom_range(0, 99) < 5) b = b | 4'(1 << $urandom_range(0, 3));
        btn_in = b;
        tick($urandom_range(1, 6));
        if ($urandom_range(0, 9) == 0) begin
          btn_in = 4'd0; tick($urandom_range(1, 3));
          btn_in = b;    tick(1);
        end
        btn_in = 4'd0;
        if ($urandom_range(0, 99) < 3) begin
          rst_input = 1'b1; tick(1); rst_input = 1'b0;
        end
        tick($urandom_range(0, 10));
      end
      tick(REL + 4);
      if (m_mode != 0) begin
        rst_input = 1'b1; tick(1); rst_input = 1'b0;
      end
    end
    wait_idle(400);
    tick(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/input_check.md
Name: input_check

Overview:
- Receive-side counterpart of the colour-streaming display block in the memory game.
- Samples the player's four colour buttons and decodes each press to a 2-bit colour.
- Compares each press against the same packed sequence the display streams, for round_ctr+1 entries.
- Reports a 1-cycle complete or fail pulse to the game FSM, and echoes the pressed colour on a colour bus so the top-level wrapper can light the LED.

Parameters:
RELEASE_CYCLES, 4, consecutive all-released synced cycles required before a press is considered finished (>=1)
TIMEOUT_W, 24, width of the inactivity counter
TIMEOUT_CYCLES, 10000000, WAIT_PRESS cycles before timeout (used only with INPUT_TIMEOUT_EN)

Ports:
clk  input  1  system clock, all logic on posedge
rst_input  input  1  reset, synchronous, active-high
en_input  input  1  start a round when the block is idle
seq_in_input  input  32  16 colours packed LSB-first; colour i = bits [2i+1:2i]
round_ctr  input  4  N means check N+1 colours (positions 0..N)
btn_in  input  4  raw asynchronous buttons, active-high; bit k = colour k
colour_bus  output  2  echoed pressed colour, valid only while colour_oe=1
colour_oe  output  1  1 = echo bus valid; 0 = wrapper tri-states the pads
busy_input  output  1  1 while not in IDLE
complete_input  output  1  1-cycle pulse: whole sequence entered correctly
fail_input  output  1  1-cycle pulse: wrong colour, multi-press, or timeout

Behaviour:
- Reset:
  - all outputs 0, colour_bus=00, state=IDLE, pos=0, synchronizer flops=0, counters=0.
  - Reset mid-round aborts the round with no pulse.
- Synchronizer: btn_in passes through 2 flops to give btn_s. All decisions use btn_s only.
- Registered outputs:
  - busy_input=1 in every state except IDLE.
  - complete_input and fail_input default to 0 each cycle.
- IDLE:
  - en_input=1 -> pos<=0, go WAIT_PRESS.
  - en_input is ignored in all other states. Deasserting it mid-round does not abort the round.
- WAIT_PRESS, when btn_s != 0 (press recognised):
  - btn_s one-hot -> colour = bit index; match flag = (colour == seq_in_input[2*pos +: 2]).
  - btn_s has more than one bit set -> match flag = 0 and colour = index of the lowest set bit.
  - Next cycle: colour_bus<=colour, colour_oe<=1; go WAIT_RELEASE with the release counter cleared.
- WAIT_RELEASE:
  - colour_oe stays 1 and colour_bus is held.
  - Any btn_s != 0 clears the release counter. Bits added during the hold are ignored.
  - btn_s == 0 increments the counter. On reaching RELEASE_CYCLES: colour_oe<=0 and the press is evaluated:
    - match=0 -> fail_input pulse, go IDLE.
    - match=1 and pos==round_ctr -> complete_input pulse, go IDLE.
    - match=1 otherwise -> pos<=pos+1, go WAIT_PRESS.
- Latency:
  - btn_in rise to colour_oe=1 is 4 cycles (2 sync, 1 recognition, 1 output register).
  - Last release to the complete/fail pulse is 2+RELEASE_CYCLES cycles.
- Boundaries:
  - round_ctr=15 checks all 16 entries; pos never wraps.
  - round_ctr is sampled continuously. It must be stable while busy_input=1 (game FSM guarantee).
  - A button already held when en_input arrives counts as the first press.
  - complete_input and fail_input are never asserted in the same cycle.

Optional Feature:
INPUT_TIMEOUT_EN
- Defined:
  - A TIMEOUT_W-bit counter runs only in WAIT_PRESS. It clears on entry to WAIT_PRESS and on press recognition.
  - On reaching TIMEOUT_CYCLES-1 with no press: fail_input pulse, go IDLE, colour_oe stays 0.
- Undefined:
  - No counter logic is built; WAIT_PRESS waits indefinitely.

Test Plan:
- Correct round: seq_in_input=32'h0000_00E4 (colours 0,1,2,3), round_ctr=3; press btn 0001, 0010, 0100, 1000, each held 10 cycles with 10-cycle gaps. Expect colour_bus echoes 0,1,2,3 with colour_oe=1 during each hold; exactly one complete_input pulse, 2+4 cycles after the last release; fail_input never 1.
- Wrong colour: same sequence, round_ctr=3; press 0001 then 0100. Expect fail_input pulse after the second release, busy_input=0 afterwards, no complete_input.
- Multi-press: round_ctr=0, seq colour 0 = 2'b01; btn_in=4'b0011 held. Expect colour_bus=00, then a fail_input pulse after release.
- Release glitch: press colour 0 correctly, drop for 2 cycles, re-press 1 cycle, then release. Expect no evaluation until 4 consecutive released synced cycles; a single result only.
- Reset mid-round: rst_input=1 while in WAIT_RELEASE with colour_oe=1. Expect the next cycle all outputs 0, busy_input=0, and no pulse after reset is released.
- INPUT_TIMEOUT_EN with TIMEOUT_CYCLES=100: en_input pulse and no buttons. Expect fail_input exactly 100 cycles after entry to WAIT_PRESS. Without the macro, no fail_input after 1000 cycles.
